// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback arbiter.
// An entry is one pending register write: destination plus value.
package wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Circular FIFO of pending long-latency results. It also exposes per-slot valid bits
// and destinations so the parent can build the pending-destination mask.
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  wb_entry_t                     push_entry,
    input  logic                          pop,
    output wb_entry_t                     head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        count,
    output logic [DEPTH-1:0][REG_AW-1:0]  ent_rd,
    output logic [DEPTH-1:0]              ent_valid
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [AW:0]                count_q, count_d;
    logic [DEPTH-1:0]           valid_q, valid_d;
    wb_entry_t [DEPTH-1:0]      mem_q, mem_d;
    logic                       do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q]   = push_entry;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
        mem_q <= mem_d;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_rd[i] = mem_q[i].rd;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign ent_valid = valid_q;

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges the in-order pipeline result and buffered long-latency results onto the single
// register-file write port. Optional starvation guard: define WB_STARVE_GUARD_EN.
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int QDEPTH       = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      pipe_we,
    input  logic [REG_AW-1:0]         pipe_rd_addr,
    input  logic [XLEN-1:0]           pipe_rd_data,
    input  logic                      lu_valid,
    output logic                      lu_ready,
    input  logic [REG_AW-1:0]         lu_rd_addr,
    input  logic [XLEN-1:0]           lu_rd_data,
    output logic                      rf_we,
    output logic [REG_AW-1:0]         rf_rd_addr,
    output logic [XLEN-1:0]           rf_rd_data,
    output logic [31:0]               pend_mask,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      pipe_stall
);

    if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("wb_write_arbiter: QDEPTH must be a power of two >= 2, STARVE_LIMIT >= 1");
    end

    logic                           pipe_sel, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic                           force_drain;
    wb_entry_t                      head, push_entry;
    logic [QDEPTH-1:0][REG_AW-1:0]  ent_rd;
    logic [QDEPTH-1:0]              ent_valid;
    logic                           rf_we_q, rf_we_d;
    logic [REG_AW-1:0]              rf_rd_addr_q, rf_rd_addr_d;
    logic [XLEN-1:0]                rf_rd_data_q, rf_rd_data_d;

    // Handshake: a result transfers on any edge where lu_valid && lu_ready; lu_ready depends
    // only on registered occupancy, and the producer holds addr/data while stalled.
    // Results for x0 are consumed but never stored.
    assign lu_ready   = !fifo_full;
    assign fifo_push  = lu_valid && lu_ready && (lu_rd_addr != '0);
    assign push_entry = '{rd: lu_rd_addr, data: lu_rd_data};
    assign pipe_sel   = pipe_we && (pipe_rd_addr != '0);

    wb_result_fifo #(.DEPTH(QDEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (q_count),
        .ent_rd     (ent_rd),
        .ent_valid  (ent_valid)
    );

`ifdef WB_STARVE_GUARD_EN
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    logic [WW-1:0] wait_q, wait_d;
    logic          stall_q, stall_d;

    // Counts cycles the head sits unpopped; saturates at the limit.
    always_comb begin
        wait_d = wait_q;
        if (fifo_empty || fifo_pop) begin
            wait_d = '0;
        end else if (wait_q != WW'(STARVE_LIMIT)) begin
            wait_d = wait_q + 1'b1;
        end
        stall_d = !fifo_empty && !fifo_pop && (wait_d == WW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            stall_q <= stall_d;
        end
    end

    assign force_drain = stall_q;
    assign pipe_stall  = stall_q;
`else
    assign force_drain = 1'b0;
    assign pipe_stall  = 1'b0;
`endif

    always_comb begin
        fifo_pop     = 1'b0;
        rf_we_d      = 1'b0;
        rf_rd_addr_d = rf_rd_addr_q;
        rf_rd_data_d = rf_rd_data_q;
        if (!fifo_empty && (force_drain || !pipe_sel)) begin
            fifo_pop     = 1'b1;
            rf_we_d      = 1'b1;
            rf_rd_addr_d = head.rd;
            rf_rd_data_d = head.data;
        end else if (pipe_sel) begin
            rf_we_d      = 1'b1;
            rf_rd_addr_d = pipe_rd_addr;
            rf_rd_data_d = pipe_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q      <= 1'b0;
            rf_rd_addr_q <= '0;
            rf_rd_data_q <= '0;
        end else begin
            rf_we_q      <= rf_we_d;
            rf_rd_addr_q <= rf_rd_addr_d;
            rf_rd_data_q <= rf_rd_data_d;
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_rd_addr = rf_rd_addr_q;
    assign rf_rd_data = rf_rd_data_q;

    // A slot's bit drops on the same edge its write is registered.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            if (ent_valid[i]) begin
                pend_mask[ent_rd[i]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter (QDEPTH=4, STARVE_LIMIT=8); the starvation
// section follows WB_STARVE_GUARD_EN.
module tb_wb_write_arbiter;

    localparam int QDEPTH = 4;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_rd_addr;
    logic [31:0] pipe_rd_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd_addr;
    logic [31:0] lu_rd_data;
    logic        rf_we;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic [31:0] pend_mask;
    logic [2:0]  q_count;
    logic        pipe_stall;

    int          n_vec = 0;
    int          n_err = 0;
    logic [36:0] exp_q[$];
    logic [36:0] e;

    wb_write_arbiter #(.QDEPTH(QDEPTH), .STARVE_LIMIT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_we      (pipe_we),
        .pipe_rd_addr (pipe_rd_addr),
        .pipe_rd_data (pipe_rd_data),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_rd_addr   (lu_rd_addr),
        .lu_rd_data   (lu_rd_data),
        .rf_we        (rf_we),
        .rf_rd_addr   (rf_rd_addr),
        .rf_rd_data   (rf_rd_data),
        .pend_mask    (pend_mask),
        .q_count      (q_count),
        .pipe_stall   (pipe_stall)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
        pipe_we      = we;
        pipe_rd_addr = a;
        pipe_rd_data = d;
    endtask

    task automatic drive_lu(input logic v, input logic [4:0] a, input logic [31:0] d);
        lu_valid   = v;
        lu_rd_addr = a;
        lu_rd_data = d;
    endtask

    // scoreboard compare
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_write(input string tag);
        e = exp_q.pop_front();
        chk({tag, "_we"}, 64'(rf_we), 64'(1));
        chk({tag, "_addr"}, 64'(rf_rd_addr), 64'(e[36:32]));
        chk({tag, "_data"}, 64'(rf_rd_data), 64'(e[31:0]));
    endtask

    initial begin
        rst = 1'b1;
        drive_pipe(1'b0, 5'd0, 32'd0);
        drive_lu(1'b0, 5'd0, 32'd0);
        tick();
        tick();
        chk("rst_we", 64'(rf_we), 64'(0));
        chk("rst_addr", 64'(rf_rd_addr), 64'(0));
        chk("rst_data", 64'(rf_rd_data), 64'(0));
        chk("rst_count", 64'(q_count), 64'(0));
        chk("rst_pend", 64'(pend_mask), 64'(0));
        chk("rst_stall", 64'(pipe_stall), 64'(0));
        chk("rst_ready", 64'(lu_ready), 64'(1));
        rst = 1'b0;

        // first pipeline write after reset, then one idle cycle holds addr/data
        drive_pipe(1'b1, 5'd5, 32'hDEAD_BEEF);
        tick();
        chk("p1_we", 64'(rf_we), 64'(1));
        chk("p1_addr", 64'(rf_rd_addr), 64'(5));
        chk("p1_data", 64'(rf_rd_data), 64'hDEAD_BEEF);
        drive_pipe(1'b0, 5'd0, 32'd0);
        tick();
        chk("p1_we_drop", 64'(rf_we), 64'(0));
        chk("p1_addr_hold", 64'(rf_rd_addr), 64'(5));
        chk("p1_data_hold", 64'(rf_rd_data), 64'hDEAD_BEEF);

        // queue while the pipeline is busy
        for (int k = 1; k <= 6; k++) begin
            drive_pipe(1'b1, 5'(k), 32'h100 + 32'(k));
            if (k <= 3) begin
                drive_lu(1'b1, 5'(6 + k), 32'h700 + 32'(k));
                exp_q.push_back({5'(6 + k), 32'h700 + 32'(k)});
            end else begin
                drive_lu(1'b0, 5'd0, 32'd0);
            end
            tick();
            chk("busy_addr", 64'(rf_rd_addr), 64'(k));
            chk("busy_data", 64'(rf_rd_data), 64'(32'h100 + 32'(k)));
        end
        chk("busy_count", 64'(q_count), 64'(3));
        chk("busy_pend", 64'(pend_mask), 64'h380);
        drive_pipe(1'b0, 5'd0, 32'd0);
        tick();
        chk_write("drain7");
        chk("drain7_pend", 64'(pend_mask), 64'h300);
        tick();
        chk_write("drain8");
        chk("drain8_pend", 64'(pend_mask), 64'h200);
        tick();
        chk_write("drain9");
        chk("drain9_pend", 64'(pend_mask), 64'h0);
        chk("drain9_count", 64'(q_count), 64'(0));
        tick();
        chk("drain_idle_we", 64'(rf_we), 64'(0));

        // fill to full with the pipe busy; slots wrap since pointers sit at 3
        drive_pipe(1'b1, 5'd10, 32'hAAAA_0010);
        for (int j = 0; j < 4; j++) begin
            chk("fill_ready", 64'(lu_ready), 64'(1));
            drive_lu(1'b1, 5'(11 + j), 32'hA00 + 32'(11 + j));
            exp_q.push_back({5'(11 + j), 32'hA00 + 32'(11 + j)});
            tick();
        end
        chk("full_count", 64'(q_count), 64'(4));
        chk("full_ready", 64'(lu_ready), 64'(0));
        chk("full_pend", 64'(pend_mask), 64'h7800);
        drive_lu(1'b1, 5'd15, 32'hA0F);
        exp_q.push_back({5'd15, 32'hA0F});
        tick();
        chk("held_count", 64'(q_count), 64'(4));
        chk("held_ready", 64'(lu_ready), 64'(0));
        chk("held_pipe_addr", 64'(rf_rd_addr), 64'(10));
        drive_pipe(1'b0, 5'd0, 32'd0);
        tick();
        chk_write("pop11");
        chk("pop11_count", 64'(q_count), 64'(3));
        chk("pop11_ready", 64'(lu_ready), 64'(1));
        tick();
        chk_write("pop12");
        chk("pop12_count", 64'(q_count), 64'(3));
        chk("pop12_pend", 64'(pend_mask), 64'hE000);
        drive_lu(1'b0, 5'd0, 32'd0);
        for (int j = 0; j < 3; j++) begin
            tick();
            chk_write("pop_tail");
        end
        chk("wrap_count", 64'(q_count), 64'(0));
        chk("wrap_pend", 64'(pend_mask), 64'h0);

        // x0 handling
        drive_pipe(1'b1, 5'd20, 32'h2020);
        drive_lu(1'b1, 5'd3, 32'h11);
        tick();
        chk("x0_q_count", 64'(q_count), 64'(1));
        chk("x0_q_pend", 64'(pend_mask), 64'h8);
        drive_pipe(1'b1, 5'd21, 32'h2121);
        drive_lu(1'b1, 5'd0, 32'h99);
        tick();
        chk("x0_lu_count", 64'(q_count), 64'(1));
        chk("x0_lu_ready", 64'(lu_ready), 64'(1));
        chk("x0_lu_pend", 64'(pend_mask), 64'h8);
        drive_lu(1'b0, 5'd0, 32'd0);
        drive_pipe(1'b1, 5'd0, 32'h55);
        tick();
        chk("x0_pipe_we", 64'(rf_we), 64'(1));
        chk("x0_pipe_addr", 64'(rf_rd_addr), 64'(3));
        chk("x0_pipe_data", 64'(rf_rd_data), 64'h11);
        chk("x0_pipe_count", 64'(q_count), 64'(0));
        tick();
        chk("x0_idle_we", 64'(rf_we), 64'(0));
        chk("x0_idle_addr", 64'(rf_rd_addr), 64'(3));

        // reset in the middle of operation
        drive_pipe(1'b1, 5'd22, 32'h2222);
        for (int j = 0; j < 3; j++) begin
            drive_lu(1'b1, 5'(4 + j), 32'h400 + 32'(j));
            tick();
        end
        chk("mid_count", 64'(q_count), 64'(3));
        chk("mid_pend", 64'(pend_mask), 64'h70);
        drive_lu(1'b0, 5'd0, 32'd0);
        drive_pipe(1'b0, 5'd0, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_count", 64'(q_count), 64'(0));
        chk("mid_rst_pend", 64'(pend_mask), 64'h0);
        chk("mid_rst_we", 64'(rf_we), 64'(0));
        tick();
        chk("mid_after_we", 64'(rf_we), 64'(0));
        chk("mid_after_count", 64'(q_count), 64'(0));

        // long busy pipeline with one queued entry
        drive_pipe(1'b1, 5'd23, 32'h2323);
        drive_lu(1'b1, 5'd9, 32'h99);
        tick();
        drive_lu(1'b0, 5'd0, 32'd0);
`ifdef WB_STARVE_GUARD_EN
        for (int j = 0; j < 7; j++) begin
            tick();
            chk("starve_wait_stall", 64'(pipe_stall), 64'(0));
            chk("starve_wait_addr", 64'(rf_rd_addr), 64'(23));
        end
        tick();
        chk("starve_stall_hi", 64'(pipe_stall), 64'(1));
        chk("starve_stall_count", 64'(q_count), 64'(1));
        tick();
        chk("starve_drain_we", 64'(rf_we), 64'(1));
        chk("starve_drain_addr", 64'(rf_rd_addr), 64'(9));
        chk("starve_drain_data", 64'(rf_rd_data), 64'h99);
        chk("starve_stall_lo", 64'(pipe_stall), 64'(0));
        chk("starve_count", 64'(q_count), 64'(0));
        tick();
        chk("starve_resume_addr", 64'(rf_rd_addr), 64'(23));
`else
        for (int j = 0; j < 12; j++) begin
            tick();
            chk("noguard_stall", 64'(pipe_stall), 64'(0));
            chk("noguard_addr", 64'(rf_rd_addr), 64'(23));
        end
        chk("noguard_count", 64'(q_count), 64'(1));
        chk("noguard_pend", 64'(pend_mask), 64'h200);
        drive_pipe(1'b0, 5'd0, 32'd0);
        tick();
        chk("noguard_drain_addr", 64'(rf_rd_addr), 64'(9));
        chk("noguard_drain_data", 64'(rf_rd_data), 64'h99);
        chk("noguard_drain_count", 64'(q_count), 64'(0));
`endif

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer side of the integer register file's single synchronous write port (we / rd_addr / rd_data).
- Merges two result sources onto that one port:
  - the in-order MEM/WB pipeline result, which has priority and never stalls;
  - a long-latency unit (multi-cycle mul/div) result, delivered by valid/ready handshake.
- Buffers long-latency results in a small FIFO and publishes a pending-destination mask so the hazard unit can stall dependent issue.

Parameters:
- XLEN, 32, data width of register values.
- REG_AW, 5, register address width (32 architectural registers).
- QDEPTH, 4, long-latency result FIFO depth; power of two, minimum 2.
- STARVE_LIMIT, 8, cycles a FIFO head may wait before a forced drain (only with the optional feature).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pipe_we  in  1  pipeline writeback request.
- pipe_rd_addr  in  REG_AW  pipeline destination register.
- pipe_rd_data  in  XLEN  pipeline result.
- lu_valid  in  1  long-latency result valid.
- lu_ready  out  1  FIFO can accept a result.
- lu_rd_addr  in  REG_AW  long-latency destination register.
- lu_rd_data  in  XLEN  long-latency result.
- rf_we  out  1  register file write enable.
- rf_rd_addr  out  REG_AW  register file write address.
- rf_rd_data  out  XLEN  register file write data.
- pend_mask  out  32  bit i = 1 while a queued result targets register i.
- q_count  out  $clog2(QDEPTH)+1  FIFO occupancy.
- pipe_stall  out  1  upstream freeze request (tied 0 without the optional feature).

Behaviour:
- Reset: clk and rst only; rst is synchronous and active-high. When rst is sampled high:
  - rf_we=0, rf_rd_addr=0, rf_rd_data=0;
  - FIFO emptied, q_count=0, pend_mask=0, pipe_stall=0.
  - Reset mid-operation discards all queued results; no write is issued in the following cycle.
- Write port timing: rf_* are registered, 1-cycle latency from the selecting edge. rf_we is high for exactly one cycle per write.
- Priority, evaluated each cycle:
  - If pipe_we=1 and pipe_rd_addr!=0: drive the pipeline result on the next cycle. The FIFO holds.
  - Otherwise, if the FIFO is non-empty: pop the head and drive it on the next cycle.
  - Otherwise: rf_we=0 next cycle; rf_rd_addr and rf_rd_data hold their previous values.
- Writes to x0:
  - A pipe write to x0 counts as idle, so the FIFO may drain that cycle.
  - An lu handshake to x0 is accepted (consumed) but not enqueued.
- Handshake:
  - lu_ready = (q_count < QDEPTH), computed combinationally from registered occupancy only.
  - Push occurs when lu_valid && lu_ready.
  - When full, no push occurs even if a pop happens in the same cycle.
  - Simultaneous push and pop in a non-full FIFO leaves q_count unchanged.
  - lu_rd_addr and lu_rd_data must stay stable while lu_valid=1 and lu_ready=0.
- FIFO: circular buffer with wrap-around read/write pointers; pops in order. An entry is {rd_addr, data}.
- pend_mask: combinational OR of one-hot(rd_addr) over all valid entries; bit 0 is always 0.
  - A popped entry's bit clears on the same edge that rf_we rises for it.
  - Duplicate destinations in the queue keep the bit set until the last such entry pops.
- Ordering: no reordering or WAW resolution inside this block. The hazard unit blocks issue to any register set in pend_mask.

Optional Feature:
- Macro: WB_STARVE_GUARD_EN.
- Defined:
  - A wait counter increments each cycle the FIFO is non-empty and its head is not popped; it resets to 0 on every pop or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, pipe_stall=1 (registered).
  - The next cycle pops the head regardless of pipe_we. The upstream stage holds its result because pipe_stall is high.
  - pipe_stall deasserts the cycle after that pop.
- Undefined: no counter; pipe_stall tied 0; FIFO drains only in pipeline-idle cycles.

Decomposition:
- Package wb_pkg holds:
  - XLEN and REG_AW constants;
  - typedef wb_entry_t {logic [REG_AW-1:0] rd; logic [XLEN-1:0] data;}.
- Sub-module wb_result_fifo: parameterised circular FIFO with push, pop, full, empty, count and flat entry/valid outputs for pend_mask generation.
- Arbitration, output registers and the starvation guard stay in the top module.

Test Plan:
- Reset: after rst, pipe_we=1, rd=5, data=0xDEAD_BEEF -> next cycle rf_we=1, rf_rd_addr=5, rf_rd_data=0xDEADBEEF; the cycle after, rf_we=0.
- Queue while busy: with pipe_we continuously 1 to rd 1..6, push lu results to rd 7, 8, 9 -> q_count=3, pend_mask=0x380; then drop pipe_we -> writes to 7, 8, 9 on consecutive cycles, in order; pend_mask returns to 0.
- Full/backpressure with QDEPTH=4 and pipe busy: 5 lu pushes -> lu_ready=0 after the 4th; the 5th is held stable; after one idle pipe cycle it is accepted; no data is lost; FIFO wrap-around is exercised.
- x0 handling: pipe_we=1 to rd=0 while the FIFO holds rd=3 / 0x11 -> rf writes rd=3 / 0x11; an lu push to rd=0 is consumed with q_count unchanged.
- Mid-operation reset: 3 entries queued, rst pulsed for one cycle -> q_count=0, pend_mask=0, no rf_we in the following cycle.
- WB_STARVE_GUARD_EN with STARVE_LIMIT=8: pipe_we held 1 and one entry queued -> pipe_stall=1 after 8 waiting cycles, head written next cycle, pipe_stall=0 the cycle after.
